// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rst_seq_pkg.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__rst_seq_pkg.sv - shared state enum, parameter minimums and counter sizing
package gf180mcu_fd_sc_mcu9t5v0__rst_seq_pkg;

   localparam int MIN_NUM_STAGES = 1;
   localparam int MIN_SYNC_DEPTH = 2;
   localparam int MIN_STRETCH    = 1;
   localparam int MIN_GAP        = 1;

   typedef enum logic [2:0] {
      ST_HOLD,
      ST_STRETCH,
      ST_RELEASE,
      ST_RUN,
      ST_SWASSERT,
      ST_SWWAIT
   } rst_seq_state_e;

   // One counter serves both the stretch and the inter-stage gap.
   function automatic int cnt_width(input int stretch, input int gap);
      int m;
      m = (stretch > gap) ? stretch : gap;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rst_sync_chain.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__rst_sync_chain.sv - async-assert, sync-release reset synchronizer
module gf180mcu_fd_sc_mcu9t5v0__rst_sync_chain #(
   parameter int DEPTH = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic sync_o
);

   logic [DEPTH-1:0] chain_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[DEPTH-2:0], 1'b1};
      end
   end

   assign sync_o = chain_q[DEPTH-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rst_seq.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__rst_seq.sv - staged reset sequencer with 4-phase SW reset
// Optional macro GF180MCU_RST_SEQ_REVERSE_ASSERT_EN stages SW assertion from the top index down.
module gf180mcu_fd_sc_mcu9t5v0__rst_seq
   import gf180mcu_fd_sc_mcu9t5v0__rst_seq_pkg::*;
#(
   parameter int NUM_STAGES = 4,
   parameter int SYNC_DEPTH = 2,
   parameter int STRETCH    = 16,
   parameter int GAP        = 4
) (
   input  logic                  CLK,
   input  logic                  RN,
   input  logic                  SW_REQ,
   output logic                  SW_ACK,
   output logic [NUM_STAGES-1:0] RSTN_O,
   output logic                  READY
);

   localparam int NS = (NUM_STAGES < MIN_NUM_STAGES) ? MIN_NUM_STAGES : NUM_STAGES;
   localparam int SD = (SYNC_DEPTH < MIN_SYNC_DEPTH) ? MIN_SYNC_DEPTH : SYNC_DEPTH;
   localparam int S  = (STRETCH < MIN_STRETCH) ? MIN_STRETCH : STRETCH;
   localparam int G  = (GAP < MIN_GAP) ? MIN_GAP : GAP;
   localparam int CW = cnt_width(S, G);

   localparam logic [CW-1:0] S_W = CW'(S);
   localparam logic [CW-1:0] G_W = CW'(G);
   localparam logic [CW-1:0] ONE = CW'(1);
   localparam logic [NS-1:0] LSB = NS'(1);

   rst_seq_state_e state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d, cnt_dec;
   logic [NS-1:0]  rstn_q, rstn_d;
   logic           ready_q, ready_d;
   logic           ack_q, ack_d;
   logic           rel_first;
   logic           sync_out;

   gf180mcu_fd_sc_mcu9t5v0__rst_sync_chain #(
      .DEPTH (SD)
   ) u_sync (
      .clk_i  (CLK),
      .rst_ni (RN),
      .sync_o (sync_out)
   );

   assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - ONE;

`ifdef GF180MCU_RST_SEQ_REVERSE_ASSERT_EN
   logic [NS-1:0] rstn_shr;
   assign rstn_shr = rstn_q >> 1;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rstn_d    = rstn_q;
      ready_d   = 1'b0;
      ack_d     = 1'b0;
      rel_first = 1'b0;
      case (state_q)
         ST_HOLD: begin
            // The edge that first sees the synchronized release is stretch cycle one.
            if (sync_out) begin
               if (S == 1) begin
                  rel_first = 1'b1;
               end else begin
                  state_d = ST_STRETCH;
                  cnt_d   = S_W - ONE;
               end
            end
         end
         ST_STRETCH: begin
            if (cnt_q <= ONE) rel_first = 1'b1;
            else              cnt_d = cnt_dec;
         end
         ST_RELEASE: begin
            if (cnt_q <= ONE) begin
               rstn_d = (rstn_q << 1) | LSB;
               if (rstn_d[NS-1]) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = G_W;
               end
            end else begin
               cnt_d = cnt_dec;
            end
         end
         ST_RUN: begin
            ready_d = 1'b1;
            if (SW_REQ) begin
               ready_d = 1'b0;
               state_d = ST_SWASSERT;
`ifdef GF180MCU_RST_SEQ_REVERSE_ASSERT_EN
               rstn_d  = rstn_shr;
               cnt_d   = rstn_shr[0] ? G_W : S_W;
`else
               rstn_d  = '0;
               cnt_d   = S_W;
`endif
            end
         end
         ST_SWASSERT: begin
`ifdef GF180MCU_RST_SEQ_REVERSE_ASSERT_EN
            // While bit 0 is still high the counter paces the top-down drop.
            if (rstn_q[0]) begin
               if (cnt_q <= ONE) begin
                  rstn_d = rstn_shr;
                  cnt_d  = rstn_shr[0] ? G_W : S_W;
               end else begin
                  cnt_d = cnt_dec;
               end
            end else
`endif
            if (cnt_q <= ONE) begin
               ack_d   = 1'b1;
               state_d = ST_SWWAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_dec;
            end
         end
         ST_SWWAIT: begin
            ack_d = 1'b1;
            if (!SW_REQ) begin
               ack_d   = 1'b0;
               state_d = ST_STRETCH;
               cnt_d   = S_W;
            end
         end
         default: begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            rstn_d  = '0;
         end
      endcase

      if (rel_first) begin
         rstn_d = LSB;
         if (NS == 1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end else begin
            state_d = ST_RELEASE;
            cnt_d   = G_W;
         end
      end
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         rstn_q  <= '0;
         ready_q <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rstn_q  <= rstn_d;
         ready_q <= ready_d;
         ack_q   <= ack_d;
      end
   end

   assign RSTN_O = rstn_q;
   assign READY  = ready_q;
   assign SW_ACK = ack_q;

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__rst_seq.md
Name: gf180mcu_fd_sc_mcu9t5v0__rst_seq

Overview:
Reset sequencer that produces staged, clock-synchronous deassertion of active-low set/reset nets (the SETN/RN pins of downstream set/reset flops) from one raw asynchronous reset.
- Assertion is immediate and asynchronous; release is synchronized, stretched, then staggered stage by stage.
- Sits at each clock-domain root in MCU designs built from this library.
- Also accepts a 4-phase software reset request.

Parameters:
NUM_STAGES, 4, number of independently released reset outputs (>=1)
SYNC_DEPTH, 2, synchronizer flops on the RN release path (>=2)
STRETCH, 16, CLK cycles held after sync before stage 0 releases (>=1)
GAP, 4, CLK cycles between consecutive stage releases (>=1)

Ports:
CLK  input  1  clock, rising edge
RN  input  1  asynchronous active-low reset
SW_REQ  input  1  software reset request, synchronous to CLK, level (4-phase)
SW_ACK  output  1  software reset acknowledge
RSTN_O  output  NUM_STAGES  active-low reset/set enables to downstream SETN/RN pins, bit 0 released first
READY  output  1  high when all stages are released and the sequencer is idle

Behaviour:
- One clock. Reset is asynchronous and active-low; ports are named CLK and RN.
- RN low, at any time and in any state: RSTN_O=0, READY=0, SW_ACK=0, sync chain=0, counter=0, state=HOLD. Applied immediately, with no clock needed.
- Release timing: edge 1 is the first CLK rising edge with RN high.
  - Sync chain output rises at edge SYNC_DEPTH.
  - STRETCH counts from the next edge.
  - RSTN_O[k] rises at edge SYNC_DEPTH+STRETCH+k*GAP.
  - READY rises one edge after the last stage.
  - Defaults give stage 0/1/2/3 at edges 18/22/26/30 and READY at 31.
- RSTN_O bits only rise one at a time, in index order. Once risen, a bit stays high until RN falls or a SW reset asserts it.
- State machine:
  - HOLD -> STRETCH when the sync chain output is 1.
  - STRETCH -> RELEASE when the counter reaches STRETCH.
  - RELEASE -> RUN after the last stage releases.
  - RUN -> SWASSERT when SW_REQ=1.
  - SWASSERT -> SWWAIT when assertion completes.
  - SWWAIT -> STRETCH when SW_REQ=0.
- SW reset:
  - In RUN, SW_REQ=1 sampled at an edge drives all RSTN_O=0 and READY=0 at that same edge.
  - SW_ACK rises STRETCH edges later and stays high while SW_REQ=1.
  - SW_REQ=0 sampled in SWWAIT: SW_ACK falls at that edge; the STRETCH + staged release repeats; READY returns.
- SW_REQ is ignored in HOLD, STRETCH and RELEASE, and SW_ACK stays 0 there. A request held high through release is taken on the first RUN edge.
- Counter: a single down/up counter of width $clog2(max(STRETCH,GAP)+1), reloaded at every state entry. It saturates, with no wrap.
- A RN glitch shorter than one cycle still fully asserts all outputs and restarts the sequence from edge 1.
- All outputs come straight from flops, with no combinational path from inputs to outputs except the async RN clear.

Optional Feature:
GF180MCU_RST_SEQ_REVERSE_ASSERT_EN
- Defined: SW reset assertion is staged in reverse order. RSTN_O[NUM_STAGES-1] falls at the SW_REQ edge, and each lower index falls GAP edges after the previous one. STRETCH counting begins after RSTN_O[0] falls, then SW_ACK rises.
- Undefined: all bits fall together, as above.
- RN assertion is always simultaneous and asynchronous in both cases.

Decomposition:
- Shared package gf180mcu_fd_sc_mcu9t5v0__rst_seq_pkg holds:
  - the state enum (HOLD, STRETCH, RELEASE, RUN, SWASSERT, SWWAIT);
  - the counter-width function;
  - the minimum legal values of the parameters.
- One sub-module, gf180mcu_fd_sc_mcu9t5v0__rst_sync_chain (SYNC_DEPTH flops cleared asynchronously by RN, D tied high). It is reused by other domain-crossing blocks.

Test Plan:
- Defaults, RN low then high before edge 1 -> RSTN_O rises 0001/0011/0111/1111 at edges 18/22/26/30; READY at 31; SW_ACK stays 0.
- RN pulled low at edge 24 (stage 1 released) -> RSTN_O=0000 and READY=0 without waiting for a clock edge; sequence restarts and stage 0 rises 18 edges after release.
- In RUN, SW_REQ=1 at edge E -> RSTN_O=0000 at E, SW_ACK=1 at E+16; SW_REQ=0 at F -> SW_ACK=0 at F, stage 0 rises at F+16, READY at F+29.
- SW_REQ=1 held from edge 5 -> ignored until RUN at edge 31; SW reset begins at edge 31.
- With GF180MCU_RST_SEQ_REVERSE_ASSERT_EN, SW_REQ=1 at edge E -> RSTN_O 0111/0011/0001/0000 at E/E+4/E+8/E+12; SW_ACK=1 at E+28.
- Parameters NUM_STAGES=1, STRETCH=1, GAP=1, SYNC_DEPTH=2 -> RSTN_O[0] rises at edge 3, READY at 4; counter does not wrap.
